// File: rtl/axi.sv
// AXI4-Lite pass-through link with an in-line protocol monitor and data scoreboard.
// The monitor's start pulse, counters and sticky flags drive the verification platform.
module axi #(
  parameter logic [31:0] C_M_START_DATA_VALUE        = 32'hAA000000,
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR  = 32'h40000000,
  parameter int          C_AXI_ADDR_WIDTH            = 32,
  parameter int          C_AXI_DATA_WIDTH            = 32,
  parameter int          C_M_TRANSACTIONS_NUM        = 4
) (
  input  logic                            i_axi_clk,
  input  logic                            i_axi_rst_n,
  input  logic                            i_axi_init_txn,
  output logic                            o_init_axi_txn,
  output logic                            o_error,
  output logic [4:0]                      o_error_code,
  output logic                            o_txn_done,
  output logic [7:0]                      o_wr_count,
  output logic [7:0]                      o_rd_count,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     m_awaddr,
  input  logic [2:0]                      m_awprot,
  input  logic                            m_awvalid,
  output logic                            m_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     m_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   m_wstrb,
  input  logic                            m_wvalid,
  output logic                            m_wready,
  output logic [1:0]                      m_bresp,
  output logic                            m_bvalid,
  input  logic                            m_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     m_araddr,
  input  logic [2:0]                      m_arprot,
  input  logic                            m_arvalid,
  output logic                            m_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]     m_rdata,
  output logic [1:0]                      m_rresp,
  output logic                            m_rvalid,
  input  logic                            m_rready,
  output logic [C_AXI_ADDR_WIDTH-1:0]     s_awaddr,
  output logic [2:0]                      s_awprot,
  output logic                            s_awvalid,
  input  logic                            s_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]     s_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   s_wstrb,
  output logic                            s_wvalid,
  input  logic                            s_wready,
  input  logic [1:0]                      s_bresp,
  input  logic                            s_bvalid,
  output logic                            s_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]     s_araddr,
  output logic [2:0]                      s_arprot,
  output logic                            s_arvalid,
  input  logic                            s_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     s_rdata,
  input  logic [1:0]                      s_rresp,
  input  logic                            s_rvalid,
  output logic                            s_rready
);
  localparam int AW    = C_AXI_ADDR_WIDTH;
  localparam int DW    = C_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int N     = C_M_TRANSACTIONS_NUM;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] BASE   = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [AW-1:0] WIN_B  = AW'(4 * N);
  localparam logic [7:0]    CNT_N  = 8'(N);

  assign s_awaddr  = m_awaddr;
  assign s_awprot  = m_awprot;
  assign s_awvalid = m_awvalid;
  assign m_awready = s_awready;
  assign s_wdata   = m_wdata;
  assign s_wstrb   = m_wstrb;
  assign s_wvalid  = m_wvalid;
  assign m_wready  = s_wready;
  assign m_bresp   = s_bresp;
  assign m_bvalid  = s_bvalid;
  assign s_bready  = m_bready;
  assign s_araddr  = m_araddr;
  assign s_arprot  = m_arprot;
  assign s_arvalid = m_arvalid;
  assign m_arready = s_arready;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rvalid  = s_rvalid;
  assign s_rready  = m_rready;

  function automatic logic in_win(input logic [AW-1:0] addr);
    return (addr >= BASE) && ((addr - BASE) < WIN_B);
  endfunction

  function automatic logic [IDX_W-1:0] sb_idx(input logic [AW-1:0] addr);
    return IDX_W'((addr - BASE) >> 2);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_d;
    for (int b = 0; b < SW; b++)
      if (strb[b]) res[8*b +: 8] = new_d[8*b +: 8];
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic init_q;
  logic aw_done, w_done, wr_out, rd_out;
  logic [AW-1:0] aw_addr_q, ar_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic [DW-1:0] sb_data [N];
  logic [N-1:0]  sb_vld;

  // previous-cycle samples for the stall-stability check
  logic          aw_pend_p1, w_pend_p1, b_pend_p1, ar_pend_p1, r_pend_p1;
  logic [AW-1:0] aw_addr_p1, ar_addr_p1;
  logic [2:0]    aw_prot_p1, ar_prot_p1;
  logic [DW-1:0] w_data_p1, r_data_p1;
  logic [SW-1:0] w_strb_p1;
  logic [1:0]    b_resp_p1, r_resp_p1;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, wr_accept;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic [SW-1:0] acc_strb;
  logic [IDX_W-1:0] acc_idx, rd_idx;
  logic [4:0] err_now;

  always_comb begin
    aw_fire   = m_awvalid & s_awready;
    w_fire    = m_wvalid & s_wready;
    b_fire    = s_bvalid & m_bready;
    ar_fire   = m_arvalid & s_arready;
    r_fire    = s_rvalid & m_rready;
    wr_accept = (aw_done | aw_fire) & (w_done | w_fire);
    acc_addr  = aw_done ? aw_addr_q : m_awaddr;
    acc_data  = w_done ? w_data_q : m_wdata;
    acc_strb  = w_done ? w_strb_q : m_wstrb;
    acc_idx   = sb_idx(acc_addr);
    rd_idx    = sb_idx(ar_addr_q);
    err_now   = '0;
    err_now[0] = (aw_pend_p1 & (!m_awvalid | (m_awaddr != aw_addr_p1) | (m_awprot != aw_prot_p1)))
               | (w_pend_p1 & (!m_wvalid | (m_wdata != w_data_p1) | (m_wstrb != w_strb_p1)))
               | (b_pend_p1 & (!s_bvalid | (s_bresp != b_resp_p1)))
               | (ar_pend_p1 & (!m_arvalid | (m_araddr != ar_addr_p1) | (m_arprot != ar_prot_p1)))
               | (r_pend_p1 & (!s_rvalid | (s_rdata != r_data_p1) | (s_rresp != r_resp_p1)));
    err_now[1] = (b_fire & (s_bresp != 2'b00)) | (r_fire & (s_rresp != 2'b00));
    err_now[2] = r_fire & rd_out & in_win(ar_addr_q) && sb_vld[rd_idx] && (s_rdata != sb_data[rd_idx]);
    err_now[3] = (s_bvalid & !wr_out) | (s_rvalid & !rd_out);
    err_now[4] = (aw_fire & !in_win(m_awaddr)) | (ar_fire & !in_win(m_araddr));
  end

  assign o_error = |o_error_code;

  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      init_q <= 1'b0; o_init_axi_txn <= 1'b0;
      o_error_code <= '0; o_txn_done <= 1'b0; o_wr_count <= '0; o_rd_count <= '0;
      aw_done <= 1'b0; w_done <= 1'b0; wr_out <= 1'b0; rd_out <= 1'b0;
      aw_addr_q <= '0; ar_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
      sb_vld <= '0;
      for (int i = 0; i < N; i++) sb_data[i] <= '0;
      aw_pend_p1 <= 1'b0; w_pend_p1 <= 1'b0; b_pend_p1 <= 1'b0; ar_pend_p1 <= 1'b0; r_pend_p1 <= 1'b0;
      aw_addr_p1 <= '0; ar_addr_p1 <= '0; aw_prot_p1 <= '0; ar_prot_p1 <= '0;
      w_data_p1 <= '0; r_data_p1 <= '0; w_strb_p1 <= '0; b_resp_p1 <= '0; r_resp_p1 <= '0;
    end else begin
      init_q         <= i_axi_init_txn;
      o_init_axi_txn <= i_axi_init_txn & ~init_q;
      // the start pulse wipes all monitor state and discards this cycle's events
      if (o_init_axi_txn) begin
        o_error_code <= '0; o_txn_done <= 1'b0; o_wr_count <= '0; o_rd_count <= '0;
        aw_done <= 1'b0; w_done <= 1'b0; wr_out <= 1'b0; rd_out <= 1'b0; sb_vld <= '0;
        aw_pend_p1 <= 1'b0; w_pend_p1 <= 1'b0; b_pend_p1 <= 1'b0; ar_pend_p1 <= 1'b0; r_pend_p1 <= 1'b0;
      end else begin
        aw_pend_p1 <= m_awvalid & ~s_awready; aw_addr_p1 <= m_awaddr; aw_prot_p1 <= m_awprot;
        w_pend_p1  <= m_wvalid & ~s_wready;   w_data_p1  <= m_wdata;  w_strb_p1  <= m_wstrb;
        b_pend_p1  <= s_bvalid & ~m_bready;   b_resp_p1  <= s_bresp;
        ar_pend_p1 <= m_arvalid & ~s_arready; ar_addr_p1 <= m_araddr; ar_prot_p1 <= m_arprot;
        r_pend_p1  <= s_rvalid & ~m_rready;   r_data_p1  <= s_rdata;  r_resp_p1  <= s_rresp;

        if (aw_fire) aw_addr_q <= m_awaddr;
        if (w_fire) begin w_data_q <= m_wdata; w_strb_q <= m_wstrb; end
        if (b_fire) begin wr_out <= 1'b0; o_wr_count <= sat_inc(o_wr_count); end
        if (wr_accept) begin
          aw_done <= 1'b0; w_done <= 1'b0; wr_out <= 1'b1;
          if (in_win(acc_addr)) begin
            sb_data[acc_idx] <= merge(sb_vld[acc_idx] ? sb_data[acc_idx] : '0, acc_data, acc_strb);
            sb_vld[acc_idx]  <= 1'b1;
          end
        end else begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end

        if (r_fire) begin rd_out <= 1'b0; o_rd_count <= sat_inc(o_rd_count); end
        if (ar_fire) begin rd_out <= 1'b1; ar_addr_q <= m_araddr; end

        o_error_code <= o_error_code | err_now;
        if (o_wr_count >= CNT_N && o_rd_count >= CNT_N) o_txn_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi.sv
// Directed-plus-random bench for the axi link: drives both master and slave sides,
// predicts counters, flags and scoreboard results from a plain word-array model.
module tb_axi;
  logic clk = 1'b0;
  logic rst_n, init_txn, init_pulse, error, txn_done;
  logic [4:0] error_code;
  logic [7:0] wr_count, rd_count;
  logic [31:0] m_awaddr, s_awaddr, m_wdata, s_wdata, m_araddr, s_araddr, m_rdata, s_rdata;
  logic [2:0]  m_awprot, s_awprot, m_arprot, s_arprot;
  logic [3:0]  m_wstrb, s_wstrb;
  logic [1:0]  m_bresp, s_bresp, m_rresp, s_rresp;
  logic m_awvalid, s_awvalid, m_awready, s_awready, m_wvalid, s_wvalid, m_wready, s_wready;
  logic m_bvalid, s_bvalid, m_bready, s_bready, m_arvalid, s_arvalid, m_arready, s_arready;
  logic m_rvalid, s_rvalid, m_rready, s_rready;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [4];
  logic [3:0]  mem_vld;
  int          exp_wr, exp_rd;
  logic [4:0]  exp_err;

  axi dut (
    .i_axi_clk(clk), .i_axi_rst_n(rst_n), .i_axi_init_txn(init_txn),
    .o_init_axi_txn(init_pulse), .o_error(error), .o_error_code(error_code),
    .o_txn_done(txn_done), .o_wr_count(wr_count), .o_rd_count(rd_count),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return a >= 32'h40000000 && a < 32'h40000010;
  endfunction

  task automatic model_clear();
    exp_wr = 0; exp_rd = 0; exp_err = '0; mem_vld = '0;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".wr_count"}, wr_count, exp_wr);
    chk({tag, ".rd_count"}, rd_count, exp_rd);
    chk({tag, ".error_code"}, error_code, exp_err);
    chk({tag, ".error"}, error, |exp_err);
    chk({tag, ".txn_done"}, txn_done, (exp_wr >= 4 && exp_rd >= 4));
  endtask

  task automatic check_fwd(input string tag, input logic rand_valids);
    m_awaddr = $urandom; m_awprot = 3'($urandom); m_wdata = $urandom; m_wstrb = 4'($urandom);
    m_araddr = $urandom; m_arprot = 3'($urandom); s_rdata = $urandom; s_bresp = 2'($urandom);
    s_rresp = 2'($urandom);
    if (rand_valids) begin
      m_awvalid = 1'($urandom); s_rvalid = 1'($urandom); m_bready = 1'($urandom); s_wready = 1'($urandom);
    end
    #1;
    chk({tag, ".awaddr"}, s_awaddr, m_awaddr);
    chk({tag, ".wdata_strb"}, {s_wdata, s_wstrb, s_awprot}, {m_wdata, m_wstrb, m_awprot});
    chk({tag, ".ar"}, {s_araddr, s_arprot}, {m_araddr, m_arprot});
    chk({tag, ".r_b"}, {m_rdata, m_rresp, m_bresp}, {s_rdata, s_rresp, s_bresp});
    chk({tag, ".hs"}, {s_awvalid, m_rvalid, s_bready, m_wready}, {m_awvalid, s_rvalid, m_bready, s_wready});
    m_awvalid = 0; s_rvalid = 0; m_bready = 0; s_wready = 0; s_bresp = 0; s_rresp = 0;
  endtask

  task automatic do_init(input string tag);
    init_txn = 1'b0;
    @(negedge clk);
    init_txn = 1'b1;
    @(negedge clk);
    chk({tag, ".pulse_hi"}, init_pulse, 1'b1);
    @(negedge clk);
    chk({tag, ".pulse_lo"}, init_pulse, 1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    chk({tag, ".pulse_stays_lo"}, init_pulse, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp);
    int order = $urandom_range(0, 2);
    int stall = $urandom_range(0, 2);
    m_awaddr = addr; m_awprot = 3'b000; m_wdata = data; m_wstrb = strb;
    m_awvalid = (order != 1); m_wvalid = (order != 0);
    repeat (stall) @(negedge clk);
    s_awready = m_awvalid; s_wready = m_wvalid;
    @(negedge clk);
    m_awvalid = 0; m_wvalid = 0; s_awready = 0; s_wready = 0;
    if (order == 0) begin m_wvalid = 1; s_wready = 1; end
    if (order == 1) begin m_awvalid = 1; s_awready = 1; end
    if (order != 2) @(negedge clk);
    m_awvalid = 0; m_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = resp; m_bready = 1;
    @(negedge clk);
    s_bvalid = 0; s_bresp = 0; m_bready = 0;
    exp_wr = (exp_wr < 255) ? exp_wr + 1 : 255;
    if (resp != 2'b00) exp_err[1] = 1'b1;
    if (!in_win(addr)) exp_err[4] = 1'b1;
    else begin
      int i = int'((addr - 32'h40000000) >> 2);
      if (!mem_vld[i]) mem[i] = '0;
      for (int b = 0; b < 4; b++) if (strb[b]) mem[i][8*b +: 8] = data[8*b +: 8];
      mem_vld[i] = 1'b1;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] resp);
    m_araddr = addr; m_arprot = 3'b000; m_arvalid = 1; s_arready = 1;
    @(negedge clk);
    m_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = rdata; s_rresp = resp; m_rready = 1;
    @(negedge clk);
    s_rvalid = 0; s_rresp = 0; m_rready = 0;
    exp_rd = (exp_rd < 255) ? exp_rd + 1 : 255;
    if (resp != 2'b00) exp_err[1] = 1'b1;
    if (!in_win(addr)) exp_err[4] = 1'b1;
    else if (mem_vld[int'((addr - 32'h40000000) >> 2)] && rdata != mem[int'((addr - 32'h40000000) >> 2)])
      exp_err[2] = 1'b1;
  endtask

  function automatic logic [31:0] model_rd(input int i);
    return mem[i];
  endfunction

  initial begin
    rst_n = 0; init_txn = 0;
    m_awaddr = 0; m_awprot = 0; m_awvalid = 0; m_wdata = 0; m_wstrb = 0; m_wvalid = 0; m_bready = 0;
    m_araddr = 0; m_arprot = 0; m_arvalid = 0; m_rready = 0;
    s_awready = 0; s_wready = 0; s_bresp = 0; s_bvalid = 0; s_arready = 0; s_rdata = 0; s_rresp = 0;
    s_rvalid = 0;
    model_clear();

    // reset held 100 ns with forwarding live
    #20;
    check_fwd("rst_fwd", 1'b1);
    chk("rst.init_pulse", init_pulse, 1'b0);
    chk("rst.state", {error, error_code, txn_done, wr_count, rd_count}, '0);
    #79;
    @(negedge clk);
    rst_n = 1;
    check_fwd("run_fwd", 1'b0);
    check_state("post_rst");

    do_init("init1");
    for (int i = 0; i < 4; i++) do_write(32'h40000000 + 4 * i, 32'hAA000001 + i, 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) do_read(32'h40000000 + 4 * i, model_rd(i), 2'b00);
    chk("pass.rd_data_model", model_rd(2), 32'hAA000003);
    check_state("pass");

    do_init("init2");
    for (int i = 0; i < 4; i++) do_write(32'h40000000 + 4 * i, 32'hAA000001 + i, 4'hF, 2'b00);
    for (int i = 0; i < 4; i++)
      do_read(32'h40000000 + 4 * i, (i == 2) ? 32'hAA000005 : model_rd(i), 2'b00);
    check_state("bad_rd3");
    chk("bad_rd3.code", error_code, 5'b00100);

    do_init("init3");
    for (int i = 0; i < 4; i++) do_write(32'h40000000 + 4 * i, $urandom, 4'hF, 2'b00);
    for (int k = 0; k < 4; k++)
      do_write(32'h40000000 + 4 * $urandom_range(0, 3), $urandom, 4'($urandom), 2'b00);
    for (int i = 0; i < 4; i++) do_read(32'h40000000 + 4 * i, model_rd(i), 2'b00);
    check_state("rand_merge");
    do_read(32'h40000004, model_rd(1) ^ (32'h1 << $urandom_range(0, 31)), 2'b00);
    check_state("rand_flip");

    do_init("init4");
    check_state("cleared4");
    m_awaddr = 32'h40000004; m_awvalid = 1; s_awready = 0;
    @(negedge clk);
    m_awvalid = 0;
    exp_err[0] = 1'b1;
    check_state("aw_drop");
    do_write(32'h40000008, $urandom, 4'hF, 2'b10);
    check_state("bresp_slverr");

    do_init("init5");
    do_write(32'h40000010, $urandom, 4'hF, 2'b00);
    check_state("aw_out_of_window");
    s_rvalid = 1; s_rdata = $urandom; m_rready = 1;
    @(negedge clk);
    s_rvalid = 0; m_rready = 0;
    exp_rd = exp_rd + 1; exp_err[3] = 1'b1;
    check_state("r_unsolicited");

    do_init("init6");
    check_state("cleared6");

    // async reset with a write accepted but its response still pending
    init_txn = 0;
    do_write(32'h40000000, $urandom, 4'hF, 2'b00);
    do_write(32'h40000004, $urandom, 4'hF, 2'b00);
    m_awaddr = 32'h40000008; m_wdata = $urandom; m_wstrb = 4'hF;
    m_awvalid = 1; s_awready = 1; m_wvalid = 1; s_wready = 1;
    @(negedge clk);
    m_awvalid = 0; s_awready = 0; m_wvalid = 0; s_wready = 0;
    chk("pre_rst.wr_count", wr_count, 8'd2);
    #2 rst_n = 0;
    #1;
    chk("async_rst.state", {error_code, txn_done, wr_count, rd_count, init_pulse}, '0);
    check_fwd("async_rst_fwd", 1'b1);
    @(negedge clk);
    rst_n = 1;
    model_clear();
    s_bvalid = 1; s_bresp = 2'b00; m_bready = 1;
    @(negedge clk);
    s_bvalid = 0; m_bready = 0;
    exp_wr = 1; exp_err[3] = 1'b1;
    check_state("b_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
